// File: rtl/sine_keystream_if.sv
// Handshake bundle between the sine-map iterator, the keystream extractor and
// the downstream cipher stage: one sample stream in, one byte stream out.
interface sine_keystream_if;
  logic [31:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;

  modport master (
    output sample_in, sample_valid, byte_ready,
    input  sample_ready, byte_out, byte_valid
  );

  modport slave (
    input  sample_in, sample_valid, byte_ready,
    output sample_ready, byte_out, byte_valid
  );
endinterface

// File: rtl/sine_keystream.sv
// Converts each float iterate in [0,1) to fixed point, extracts 24 key bits and
// queues them as three bytes in a small FIFO; unusable or unroomed samples are counted.
module sine_keystream #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  sine_keystream_if.slave              ks,
  output logic [CNT_W-1:0]             drop_count,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, CONV, PUSH} state_t;

  state_t            state, state_nxt;
  logic [1:0]        idx, idx_nxt;
  logic [31:0]       sample_p0;
  logic [24:0]       conv_res;
  logic [23:0]       key_p1;
  logic              reject_p1;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_nxt;
  logic [LVL_W-1:0]  free, level_after_pop;
  logic              accept, drop, push, pop;
  logic [7:0]        push_byte, head_nxt;
  logic              head_load;

  // Returns {reject, key}; key = frac[30:7] of the 32-bit unsigned fixed-point value.
  function automatic logic [24:0] convert(input logic [31:0] x);
    logic [7:0]  e;
    logic [7:0]  sh;
    logic [31:0] frac;
    logic        rej;
    e    = x[30:23];
    rej  = x[31] || (e >= 8'd127);
    frac = '0;
    sh   = '0;
    if (!rej && e != 8'd0) begin
      sh   = 8'd126 - e;
      frac = (sh >= 8'd32) ? 32'd0 : ({1'b1, x[22:0], 8'd0} >> sh);
    end
    return {rej, 24'(frac >> 7)};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign free            = DEPTH_L - fifo_level;
  assign ks.sample_ready = (state == IDLE) && (free >= LVL_W'(3));
  assign ks.byte_valid   = (fifo_level != '0);
  assign accept          = ks.sample_valid && ks.sample_ready;
  assign drop            = ((state == IDLE) && ks.sample_valid && !ks.sample_ready) ||
                           ((state == PUSH) && reject_p1);
  assign push            = (state == PUSH) && !reject_p1;
  assign pop             = ks.byte_valid && ks.byte_ready;
  assign conv_res        = convert(sample_p0);

  always_comb begin
    push_byte = key_p1[7:0];
    case (idx)
      2'd0:    push_byte = key_p1[23:16];
      2'd1:    push_byte = key_p1[15:8];
      default: push_byte = key_p1[7:0];
    endcase
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: if (accept) state_nxt = CONV;
      CONV: begin
        state_nxt = PUSH;
        idx_nxt   = '0;
      end
      PUSH: begin
        if (reject_p1 || idx == 2'd2) state_nxt = IDLE;
        else                          idx_nxt   = idx + 2'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The head register must see a byte written into an otherwise-empty slot on the same edge.
  always_comb begin
    rd_nxt          = rd_ptr + PTR_W'(pop);
    level_after_pop = fifo_level - LVL_W'(pop);
    head_load       = 1'b1;
    head_nxt        = mem[rd_nxt];
    if (level_after_pop == '0) begin
      head_load = push;
      head_nxt  = push_byte;
    end
  end

  // Stage p0: latch accepted iterate; stage p1: registered key; FIFO storage
  always_ff @(posedge clk) begin
    if (accept)          sample_p0   <= ks.sample_in;
    if (state == CONV)   key_p1      <= conv_res[23:0];
    if (push)            mem[wr_ptr] <= push_byte;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      idx         <= '0;
      reject_p1   <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      drop_count  <= '0;
      ks.byte_out <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (state == CONV) reject_p1 <= conv_res[24];
      if (drop)          drop_count <= sat_inc(drop_count);
      if (push)          wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)           rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_level <= fifo_level + LVL_W'(push) - LVL_W'(pop);
      if (head_load)     ks.byte_out <= head_nxt;
    end
  end
endmodule

// File: tb/tb_sine_keystream.sv
// Bench for sine_keystream: directed vectors plus randomized traffic against a
// cycle-level reference model of conversion, FIFO occupancy and drop counting.
module tb_sine_keystream;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic                      clk = 1'b0;
  logic                      reset_n = 1'b0;
  logic [CNT_W-1:0]          drop_count;
  logic [$clog2(DEPTH):0]    fifo_level;

  sine_keystream_if bus();

  sine_keystream #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .ks(bus),
    .drop_count(drop_count), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0]       mq[$];
  logic [7:0]       got[$];
  logic [7:0]       exp_pop[$];
  int               sched_due[$];
  logic [7:0]       sched_b[$];
  int               drop_due[$];
  int               m_busy = 0;
  logic [CNT_W-1:0] exp_drop = '0;
  bit               dut_acc;

  // Key = floor(x * 2^25) mod 2^24 for a float x in [0,1).
  function automatic logic [23:0] model_key(input logic [31:0] x);
    longint mant;
    int     e;
    e    = int'(x[30:23]);
    mant = longint'({1'b1, x[22:0]});
    if (e == 0) return 24'd0;
    if (e >= 125) mant = mant << (e - 125);
    else          mant = mant >> (125 - e);
    return mant[23:0];
  endfunction

  function automatic bit model_reject(input logic [31:0] x);
    return x[31] || (x[30:23] >= 8'd127);
  endfunction

  function automatic logic [31:0] rand_valid();
    logic [31:0] x;
    x        = $urandom;
    x[31]    = 1'b0;
    x[30:23] = 8'($urandom_range(0, 126));
    return x;
  endfunction

  task automatic model_clear();
    mq.delete(); got.delete(); exp_pop.delete();
    sched_due.delete(); sched_b.delete(); drop_due.delete();
    m_busy = 0;
    exp_drop = '0;
  endtask

  // Advance one clock; the model follows the same edge from the pre-edge inputs.
  task automatic tick();
    bit          m_idle, m_ready;
    logic [23:0] k;
    if (bus.byte_valid && bus.byte_ready) got.push_back(bus.byte_out);
    dut_acc = bus.sample_valid && bus.sample_ready;
    m_idle  = (m_busy == 0);
    m_ready = m_idle && (DEPTH - mq.size() >= 3);
    if (m_busy > 0) m_busy--;
    if (bus.sample_valid && m_ready) begin
      if (model_reject(bus.sample_in)) begin
        m_busy = 2;
        drop_due.push_back(cyc + 2);
      end else begin
        m_busy = 4;
        k = model_key(bus.sample_in);
        for (int i = 0; i < 3; i++) begin
          sched_due.push_back(cyc + 2 + i);
          sched_b.push_back(8'(k >> (16 - 8 * i)));
        end
      end
    end else if (bus.sample_valid && m_idle) begin
      if (exp_drop != '1) exp_drop++;
    end
    if (bus.byte_ready && mq.size() > 0) exp_pop.push_back(mq.pop_front());
    while (sched_due.size() > 0 && sched_due[0] == cyc) begin
      void'(sched_due.pop_front());
      mq.push_back(sched_b.pop_front());
    end
    while (drop_due.size() > 0 && drop_due[0] == cyc) begin
      void'(drop_due.pop_front());
      if (exp_drop != '1) exp_drop++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [31:0] x);
    bus.sample_in    = x;
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    bus.sample_valid = 1'b0;
    reset_n = 1'b0;
    model_clear();
    @(posedge clk); #1; cyc++;
    reset_n = 1'b1;
    @(posedge clk); #1; cyc++;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (bus.byte_valid !== 1'b0) begin fails++; $display("FAIL reset_byte_valid got %0h exp 0", bus.byte_valid); end
    tests++; if (bus.byte_out !== 8'h00) begin fails++; $display("FAIL reset_byte_out got %0h exp 0", bus.byte_out); end
    tests++; if (drop_count !== '0) begin fails++; $display("FAIL reset_drop_count got %0h exp 0", drop_count); end
    tests++; if (fifo_level !== '0) begin fails++; $display("FAIL reset_fifo_level got %0h exp 0", fifo_level); end
    tests++; if (bus.sample_ready !== 1'b1) begin fails++; $display("FAIL reset_sample_ready got %0h exp 1", bus.sample_ready); end
  endtask

  task automatic test_basic();
    logic [7:0] exp_b [3];
    bit         ev;
    exp_b = '{8'hAC, 8'h8B, 8'h44};
    bus.byte_ready = 1'b1;
    send(32'h3F5645A2);
    tests++; if (dut_acc !== 1'b1) begin fails++; $display("FAIL basic_accept got %0h exp 1", dut_acc); end
    for (int t = 0; t < 6; t++) begin
      ev = (t >= 2 && t <= 4);
      tests++; if (bus.byte_valid !== ev) begin fails++; $display("FAIL basic_valid t=%0d got %0h exp %0h", t, bus.byte_valid, ev); end
      if (ev) begin
        tests++; if (bus.byte_out !== exp_b[t-2]) begin fails++; $display("FAIL basic_byte t=%0d got %0h exp %0h", t, bus.byte_out, exp_b[t-2]); end
      end
      tests++; if (bus.sample_ready !== (t >= 4)) begin fails++; $display("FAIL basic_ready t=%0d got %0h exp %0h", t, bus.sample_ready, (t >= 4)); end
      tick();
    end
    tests++; if (drop_count !== '0) begin fails++; $display("FAIL basic_drop got %0h exp 0", drop_count); end
  endtask

  task automatic test_values();
    logic [31:0] xs [4];
    logic [23:0] kv [4];
    logic [31:0] x;
    logic [23:0] ek;
    xs = '{32'h3F000000, 32'h3E800000, 32'h00000000, 32'h3F5645A2};
    kv = '{24'h000000, 24'h800000, 24'h000000, 24'hAC8B44};
    bus.byte_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      x  = (i < 4) ? xs[i] : rand_valid();
      ek = (i < 4) ? kv[i] : model_key(x);
      got.delete(); exp_pop.delete();
      send(x);
      repeat (5) tick();
      tests++;
      if (got.size() != 3) begin
        fails++; $display("FAIL value_count x=%h got %0d exp 3", x, got.size());
      end else if ({got[0], got[1], got[2]} !== ek) begin
        fails++; $display("FAIL value_key x=%h got %h exp %h", x, {got[0], got[1], got[2]}, ek);
      end
    end
    tests++; if (drop_count !== '0) begin fails++; $display("FAIL value_drop got %0h exp 0", drop_count); end
  endtask

  task automatic test_reject();
    logic [31:0] xs [3];
    logic [31:0] x;
    xs = '{32'h3F800000, 32'hBF000000, 32'h7FC00000};
    bus.byte_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(xs[i]);
      tests++; if (dut_acc !== 1'b1) begin fails++; $display("FAIL reject_accept x=%h got %0h exp 1", xs[i], dut_acc); end
      tests++; if (bus.sample_ready !== 1'b0) begin fails++; $display("FAIL reject_ready0 x=%h got %0h exp 0", xs[i], bus.sample_ready); end
      tick();
      tests++; if (bus.sample_ready !== 1'b0) begin fails++; $display("FAIL reject_ready1 x=%h got %0h exp 0", xs[i], bus.sample_ready); end
      tick();
      tests++; if (bus.sample_ready !== 1'b1) begin fails++; $display("FAIL reject_ready2 x=%h got %0h exp 1", xs[i], bus.sample_ready); end
      tests++; if (fifo_level !== '0) begin fails++; $display("FAIL reject_level x=%h got %0h exp 0", xs[i], fifo_level); end
    end
    tests++; if (drop_count !== 16'd3) begin fails++; $display("FAIL reject_drop3 got %0h exp 3", drop_count); end
    for (int i = 0; i < 5; i++) begin
      x = $urandom;
      if (!x[31]) x[30:23] = 8'($urandom_range(127, 255));
      send(x);
      tick(); tick();
    end
    tests++; if (drop_count !== exp_drop) begin fails++; $display("FAIL reject_drop_rand got %0h exp %0h", drop_count, exp_drop); end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.byte_ready = 1'b0;
    send(rand_valid()); repeat (4) tick();
    send(rand_valid()); repeat (4) tick();
    tests++; if (fifo_level !== 4'd6) begin fails++; $display("FAIL bp_level6 got %0d exp 6", fifo_level); end
    tests++; if (bus.sample_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_full got %0h exp 0", bus.sample_ready); end
    send(rand_valid());
    tests++; if (dut_acc !== 1'b0) begin fails++; $display("FAIL bp_third_acc got %0h exp 0", dut_acc); end
    tests++; if (drop_count !== 16'd1) begin fails++; $display("FAIL bp_drop got %0h exp 1", drop_count); end
    bus.byte_ready = 1'b1;
    tick();
    bus.byte_ready = 1'b0;
    tests++; if (fifo_level !== 4'd5) begin fails++; $display("FAIL bp_level5 got %0d exp 5", fifo_level); end
    tests++; if (bus.sample_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_room got %0h exp 1", bus.sample_ready); end
    send(rand_valid());
    tests++; if (dut_acc !== 1'b1) begin fails++; $display("FAIL bp_next_acc got %0h exp 1", dut_acc); end
    repeat (4) tick();
    bus.byte_ready = 1'b1;
    repeat (12) tick();
    tests++; if (got.size() != 9 || exp_pop.size() != 9) begin fails++; $display("FAIL bp_count got %0d exp 9 (model %0d)", got.size(), exp_pop.size()); end
    for (int i = 0; i < got.size() && i < exp_pop.size(); i++) begin
      tests++; if (got[i] !== exp_pop[i]) begin fails++; $display("FAIL bp_byte i=%0d got %h exp %h", i, got[i], exp_pop[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] x;
    do_reset();
    bus.byte_ready = 1'b0;
    for (int n = 0; n < 6; n++) begin
      bus.byte_ready = ~bus.byte_ready;
      send(rand_valid());
      for (int t = 0; t < 5; t++) begin
        tests++; if (fifo_level !== 4'(mq.size())) begin fails++; $display("FAIL toggle_level n=%0d got %0d exp %0d", n, fifo_level, mq.size()); end
        bus.byte_ready = ~bus.byte_ready;
        tick();
      end
    end
    for (int c = 0; c < 300; c++) begin
      bus.byte_ready   = ($urandom_range(0, 2) != 0);
      bus.sample_valid = ($urandom_range(0, 3) == 0);
      x = $urandom;
      if ($urandom_range(0, 2) != 0) x = rand_valid();
      bus.sample_in = x;
      tick();
      bus.sample_valid = 1'b0;
      tests++; if (fifo_level !== 4'(mq.size())) begin fails++; $display("FAIL rand_level c=%0d got %0d exp %0d", c, fifo_level, mq.size()); end
      tests++; if (bus.sample_ready !== ((m_busy == 0) && (DEPTH - mq.size() >= 3))) begin fails++; $display("FAIL rand_ready c=%0d got %0h", c, bus.sample_ready); end
    end
    bus.byte_ready = 1'b1;
    repeat (12) tick();
    tests++; if (drop_count !== exp_drop) begin fails++; $display("FAIL rand_drop got %0h exp %0h", drop_count, exp_drop); end
    tests++; if (got.size() != exp_pop.size()) begin fails++; $display("FAIL rand_count got %0d exp %0d", got.size(), exp_pop.size()); end
    for (int i = 0; i < got.size() && i < exp_pop.size(); i++) begin
      tests++; if (got[i] !== exp_pop[i]) begin fails++; $display("FAIL rand_byte i=%0d got %h exp %h", i, got[i], exp_pop[i]); end
    end
  endtask

  task automatic test_reset_mid_push();
    logic [7:0] exp_b [3];
    exp_b = '{8'hAC, 8'h8B, 8'h44};
    do_reset();
    bus.byte_ready = 1'b1;
    send(32'h3F800000); tick(); tick();
    bus.byte_ready = 1'b0;
    send(32'h3F5645A2); repeat (4) tick();
    send(rand_valid()); tick(); tick();
    tests++; if (fifo_level !== 4'd4) begin fails++; $display("FAIL mid_level4 got %0d exp 4", fifo_level); end
    reset_n = 1'b0;
    #2;
    tests++; if (bus.byte_valid !== 1'b0) begin fails++; $display("FAIL mid_valid got %0h exp 0", bus.byte_valid); end
    tests++; if (fifo_level !== '0) begin fails++; $display("FAIL mid_level got %0d exp 0", fifo_level); end
    tests++; if (bus.byte_out !== 8'h00) begin fails++; $display("FAIL mid_byte_out got %h exp 0", bus.byte_out); end
    tests++; if (drop_count !== '0) begin fails++; $display("FAIL mid_drop got %0h exp 0", drop_count); end
    model_clear();
    @(posedge clk); #1; cyc++;
    reset_n = 1'b1;
    tick();
    bus.byte_ready = 1'b1;
    send(32'h3F5645A2);
    repeat (6) tick();
    tests++;
    if (got.size() != 3) begin
      fails++; $display("FAIL mid_after_count got %0d exp 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (i > 0) tests++;
        if (got[i] !== exp_b[i]) begin fails++; $display("FAIL mid_after_byte i=%0d got %h exp %h", i, got[i], exp_b[i]); end
      end
    end
  endtask

  initial begin
    bus.sample_in    = '0;
    bus.sample_valid = 1'b0;
    bus.byte_ready   = 1'b0;
    test_reset();
    test_basic();
    test_values();
    test_reject();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_push();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sine_keystream.md
# sine_keystream

Keystream extractor directly downstream of the sine-map iterator. It accepts each new IEEE-754 single-precision iterate x_n (nominally in [0,1)) and converts it to 32-bit unsigned fixed point. It extracts 24 key bits and pushes them as three bytes into an 8-entry byte FIFO, which feeds the cipher/XOR stage through a valid/ready handshake. Iterates that are out of range, or that arrive when there is no room, are dropped and counted.

## Interface

Parameters:
- FIFO_DEPTH, 8, byte FIFO entries (power of two, ≥4)
- CNT_W, 16, width of drop counter

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- sample_in  in  32  IEEE-754 single, iterate from sine map
- sample_valid  in  1  sample_in holds a new iterate
- sample_ready  out  1  block will accept sample this cycle
- byte_out  out  8  keystream byte at FIFO head
- byte_valid  out  1  FIFO non-empty
- byte_ready  in  1  consumer takes byte_out this cycle
- drop_count  out  CNT_W  saturating count of dropped samples
- fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation

- State machine with three states: IDLE, CONV, PUSH.
- sample_ready = (state==IDLE) && (free entries ≥ 3), where free = FIFO_DEPTH − fifo_level.
- Accept: sample_valid && sample_ready in IDLE. Latch sample_in, go to CONV.
- Drop: sample_valid && state==IDLE && !sample_ready. The sample is discarded, drop_count increments, and state stays IDLE. sample_valid outside IDLE is ignored and not counted.
- CONV (1 cycle). Let s = bit31, e = bits30:23, m = bits22:0.
  - s=1 or e≥127 (negative, ≥1.0, Inf, NaN): reject, increment drop_count, return to IDLE. No bytes are pushed.
  - e=0 (zero/denormal): frac = 0.
  - Otherwise frac[31:0] = {1,m,8'b0} >> (126−e). A shift of ≥32 gives 0.
  - Key K[23:0] = frac[30:7]. Register K and go to PUSH.
- PUSH (3 cycles): write K[23:16], K[15:8], K[7:0] in that order, one per cycle, then return to IDLE.
- FIFO: a pop is byte_valid && byte_ready. A simultaneous push and pop leaves the level unchanged. The admission check guarantees no overflow; pops during PUSH only add space. byte_out is the registered FIFO head and is held while byte_valid && !byte_ready.
- drop_count saturates at all-ones and does not wrap.

## Timing

- Reset (async assert, sync release) sets state IDLE, FIFO empty, byte_valid=0, byte_out=0, drop_count=0, fifo_level=0. sample_ready is 1 after release.
- Reset mid-PUSH: any partial bytes are discarded, and the FIFO empties immediately.
- Accept at edge T:
  - CONV occupies cycle T→T+1.
  - Pushes occur at edges T+2, T+3, T+4.
  - First byte: byte_valid high after edge T+2 (T+3 cycle), assuming the FIFO was empty.
- sample_ready is low from T+1 through T+4. It is high again in the cycle after edge T+4 if free ≥ 3.
- Minimum sample interval is 5 cycles. The sine iterator is far slower (~60 cycles), so drops in normal operation indicate a stalled consumer.
- Rejected sample accepted at T: back in IDLE after edge T+2, with drop_count updated at that edge.
- Pop latency: the next byte appears on byte_out one cycle after the pop edge. Back-to-back pops give one byte per cycle.

## Test plan

- Reset, then sample 0x3F5645A2 (0.837) with byte_ready=1:
  - Bytes are 0xAC, 0x8B, 0x44 on consecutive cycles.
  - First byte_valid appears 3 cycles after acceptance.
  - drop_count=0.
- Sample 0x3F000000 (0.5) gives bytes 00,00,00. Sample 0x3E800000 (0.25) gives bytes 80,00,00. Sample 0x00000000 gives 00,00,00 and is not a drop.
- Samples 0x3F800000 (1.0), 0xBF000000 (−0.5) and 0x7FC00000 (NaN):
  - No bytes are pushed.
  - drop_count=3.
  - sample_ready returns 2 cycles after each acceptance.
- byte_ready=0, then feed valid samples every 5 cycles:
  - After 2 samples, fifo_level=6 and sample_ready=0.
  - The 3rd sample is dropped, giving drop_count=1.
  - Then raise byte_ready for 1 cycle: level=5, sample_ready=1, and the next sample is accepted.
- Simultaneous push/pop with byte_ready toggling every cycle during PUSH: the byte order is preserved, and fifo_level tracks (pushes − pops) exactly.
- Assert reset_n low midway through PUSH with the FIFO holding 4 bytes: byte_valid drops immediately, and all outputs take their reset values. After release, a new 0.837 sample yields AC, 8B, 44 with no stale bytes.
